// File: rtl/vdp_host_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vdp_host_pkg
// Purpose  : Shared constants for the VDP host port. This package holds the
//            register offsets, the address width and the fill FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package vdp_host_pkg;

  localparam int VDP_ADDR_W = 14;

  localparam logic [2:0] REG_PTR_LO   = 3'd0;
  localparam logic [2:0] REG_PTR_HI   = 3'd1;
  localparam logic [2:0] REG_DATA     = 3'd2;
  localparam logic [2:0] REG_INCR     = 3'd3;
  localparam logic [2:0] REG_FILL_LO  = 3'd4;
  localparam logic [2:0] REG_FILL_HI  = 3'd5;
  localparam logic [2:0] REG_FILL_VAL = 3'd6;
  localparam logic [2:0] REG_STATUS   = 3'd7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

endpackage
`default_nettype wire

// File: rtl/vdp_fill_engine.sv
`default_nettype none
// ============================================================================
// Module   : vdp_fill_engine
// Purpose  : Block-fill sequencer. It owns the fill count, the IDLE/FILL FSM
//            and the busy flag. It raises 'advance' on every cycle in which
//            the parent must emit one fill write and step the pointer.
// Revision : 1.0 - initial release
// ============================================================================
module vdp_fill_engine
  import vdp_host_pkg::*;
#(
  parameter int CNT_WIDTH = VDP_ADDR_W
) (
  input  logic       write_clk,
  input  logic       reset,
  input  logic       cnt_lo_we,
  input  logic       cnt_hi_we,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       advance
);

  fill_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_new;

  // State and count registers.
  always_ff @(posedge write_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The first write is issued on the trigger cycle itself. The strobes then
  // line up exactly with the cycles in which busy is high.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    advance = 1'b0;
    cnt_new = {wdata[CNT_WIDTH-9:0], cnt_q[7:0]};
    case (state_q)
      IDLE: begin
        if (cnt_lo_we) begin
          cnt_d = {cnt_q[CNT_WIDTH-1:8], wdata};
        end else if (cnt_hi_we) begin
          if (cnt_new != '0) begin
            state_d = FILL;
            advance = 1'b1;
            cnt_d   = cnt_new - CNT_WIDTH'(1);
          end else begin
            cnt_d = cnt_new;
          end
        end
      end
      FILL: begin
        if (cnt_q != '0) begin
          advance = 1'b1;
          cnt_d   = cnt_q - CNT_WIDTH'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == FILL);

endmodule
`default_nettype wire

// File: rtl/vdp_host_port.sv
`default_nettype none
// ============================================================================
// Module   : vdp_host_port
// Purpose  : CPU register interface that produces the VDP memory write
//            stream. It provides an auto-incrementing address pointer, a
//            data port and an optional block-fill engine.
// Config   : define VDP_HOST_FILL_EN to build the fill engine (registers 4-6
//            and the busy flag). Without it, busy is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module vdp_host_port
  import vdp_host_pkg::*;
#(
  parameter int ADDR_WIDTH = VDP_ADDR_W,
  parameter int RESET_INCR = 1
) (
  input  logic                  write_clk,
  input  logic                  reset,
  input  logic                  cpu_sel,
  input  logic                  cpu_wr,
  input  logic [2:0]            cpu_reg,
  input  logic [7:0]            cpu_wdata,
  output logic [7:0]            cpu_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [7:0]            write_data,
  output logic                  write_enable
);

  localparam int HI_W = ADDR_WIDTH - 8;

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, ptr_next;
  logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [7:0]            incr_q, incr_d;
  logic [7:0]            write_data_q, write_data_d;
  logic [7:0]            cpu_rdata_q, cpu_rdata_d;
  logic                  write_enable_q, write_enable_d;
  logic [7:0]            fill_val;
  logic                  busy_w, fill_adv, wr_ok, rd_req;

  // A write that arrives while busy is dropped. This includes the final
  // fill cycle.
  assign wr_ok    = cpu_sel & cpu_wr & ~busy_w;
  assign rd_req   = cpu_sel & ~cpu_wr;
  assign ptr_next = ptr_q + {{HI_W{1'b0}}, incr_q};

`ifdef VDP_HOST_FILL_EN
  logic [7:0] fill_val_q, fill_val_d;

  // Fill value register.
  always_comb begin
    fill_val_d = fill_val_q;
    if (wr_ok && cpu_reg == REG_FILL_VAL) fill_val_d = cpu_wdata;
  end

  // Fill value storage.
  always_ff @(posedge write_clk or posedge reset) begin
    if (reset) fill_val_q <= 8'h00;
    else       fill_val_q <= fill_val_d;
  end

  vdp_fill_engine #(
    .CNT_WIDTH (ADDR_WIDTH)
  ) u_fill_engine (
    .write_clk (write_clk),
    .reset     (reset),
    .cnt_lo_we (wr_ok && cpu_reg == REG_FILL_LO),
    .cnt_hi_we (wr_ok && cpu_reg == REG_FILL_HI),
    .wdata     (cpu_wdata),
    .busy      (busy_w),
    .advance   (fill_adv)
  );

  assign fill_val = fill_val_q;
`else
  assign fill_adv = 1'b0;
  assign busy_w   = 1'b0;
  assign fill_val = 8'h00;
`endif

  // Pointer/register updates, the write-port output mux and read data select.
  always_comb begin
    ptr_d          = ptr_q;
    incr_d         = incr_q;
    write_enable_d = 1'b0;
    write_addr_d   = write_addr_q;
    write_data_d   = write_data_q;
    cpu_rdata_d    = cpu_rdata_q;

    if (fill_adv) begin
      write_enable_d = 1'b1;
      write_addr_d   = ptr_q;
      write_data_d   = fill_val;
      ptr_d          = ptr_next;
    end else if (wr_ok) begin
      case (cpu_reg)
        REG_PTR_LO: ptr_d  = {ptr_q[ADDR_WIDTH-1:8], cpu_wdata};
        REG_PTR_HI: ptr_d  = {cpu_wdata[HI_W-1:0], ptr_q[7:0]};
        REG_DATA: begin
          write_enable_d = 1'b1;
          write_addr_d   = ptr_q;
          write_data_d   = cpu_wdata;
          ptr_d          = ptr_next;
        end
        REG_INCR:   incr_d = cpu_wdata;
        default:    ;
      endcase
    end

    if (rd_req) begin
      case (cpu_reg)
        REG_PTR_LO:   cpu_rdata_d = ptr_q[7:0];
        REG_PTR_HI:   cpu_rdata_d = 8'(ptr_q >> 8);
        REG_INCR:     cpu_rdata_d = incr_q;
        REG_FILL_VAL: cpu_rdata_d = fill_val;
        REG_STATUS:   cpu_rdata_d = {7'b0, busy_w};
        default:      cpu_rdata_d = 8'h00;
      endcase
    end
  end

  // Architectural state and output registers.
  always_ff @(posedge write_clk or posedge reset) begin
    if (reset) begin
      ptr_q          <= '0;
      incr_q         <= 8'(RESET_INCR);
      write_enable_q <= 1'b0;
      write_addr_q   <= '0;
      write_data_q   <= 8'h00;
      cpu_rdata_q    <= 8'h00;
    end else begin
      ptr_q          <= ptr_d;
      incr_q         <= incr_d;
      write_enable_q <= write_enable_d;
      write_addr_q   <= write_addr_d;
      write_data_q   <= write_data_d;
      cpu_rdata_q    <= cpu_rdata_d;
    end
  end

  assign write_enable = write_enable_q;
  assign write_addr   = write_addr_q;
  assign write_data   = write_data_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign busy         = busy_w;

endmodule
`default_nettype wire

// File: tb/tb_vdp_host_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_vdp_host_port
// Purpose  : Self-checking bench for vdp_host_port. It keeps a transaction-
//            level model that schedules expected strobes and busy cycles by
//            cycle number.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vdp_host_port;

`ifdef VDP_HOST_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  logic        write_clk = 1'b0;
  logic        reset;
  logic        cpu_sel, cpu_wr;
  logic [2:0]  cpu_reg;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        busy;
  logic [13:0] write_addr;
  logic [7:0]  write_data;
  logic        write_enable;

  vdp_host_port #(.ADDR_WIDTH(14), .RESET_INCR(1)) dut (
    .write_clk    (write_clk),
    .reset        (reset),
    .cpu_sel      (cpu_sel),
    .cpu_wr       (cpu_wr),
    .cpu_reg      (cpu_reg),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .busy         (busy),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_enable (write_enable)
  );

  always #5 write_clk = ~write_clk;

  int cyc = 0;
  always @(posedge write_clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  function automatic void check(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  // Model state. Expected strobes and busy cycles are keyed by cycle number.
  int m_ptr, m_incr, m_fval, m_cnt, busy_until;
  int last_addr, last_data;
  int exp_addr[int];
  int exp_data[int];
  bit exp_busy[int];

  function automatic void model_reset();
    m_ptr = 0; m_incr = 1; m_fval = 0; m_cnt = 0; busy_until = -1;
    last_addr = 0; last_data = 0;
  endfunction

  function automatic void model_write(input int n, input int r, input int d);
    if (n <= busy_until) return;
    case (r)
      0: m_ptr = (m_ptr & 'h3F00) | d;
      1: m_ptr = ((d & 'h3F) << 8) | (m_ptr & 'hFF);
      2: begin
        exp_addr[n+1] = m_ptr; exp_data[n+1] = d;
        m_ptr = (m_ptr + m_incr) % 16384;
      end
      3: m_incr = d;
      4: if (FILL_EN) m_cnt = (m_cnt & 'h3F00) | d;
      5: if (FILL_EN) begin
        m_cnt = ((d & 'h3F) << 8) | (m_cnt & 'hFF);
        for (int k = 1; k <= m_cnt; k++) begin
          exp_addr[n+k] = m_ptr; exp_data[n+k] = m_fval; exp_busy[n+k] = 1'b1;
          m_ptr = (m_ptr + m_incr) % 16384;
        end
        if (m_cnt > 0) busy_until = n + m_cnt;
        m_cnt = 0;
      end
      6: if (FILL_EN) m_fval = d;
      default: ;
    endcase
  endfunction

  function automatic int m_rd(input int r);
    case (r)
      0: return m_ptr & 'hFF;
      1: return m_ptr >> 8;
      3: return m_incr;
      6: return m_fval;
      7: return (cyc <= busy_until) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  // Per-cycle comparison of the write port and busy flag against the model.
  bit e_we;
  always @(negedge write_clk) begin
    if (chk_en) begin
      e_we = exp_addr.exists(cyc);
      check("write_enable", int'(write_enable), int'(e_we));
      if (e_we) begin
        last_addr = exp_addr[cyc];
        last_data = exp_data[cyc];
      end
      check("write_addr", int'(write_addr), last_addr);
      check("write_data", int'(write_data), last_data);
      check("busy", int'(busy), int'(exp_busy.exists(cyc)));
    end
  end

  task automatic wr(input int r, input int d);
    cpu_sel = 1'b1; cpu_wr = 1'b1; cpu_reg = r[2:0]; cpu_wdata = d[7:0];
    model_write(cyc, r, d);
    @(posedge write_clk); #1;
    cpu_sel = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic rd(input int r, input int exp, input string nm);
    cpu_sel = 1'b1; cpu_wr = 1'b0; cpu_reg = r[2:0];
    @(posedge write_clk); #1;
    cpu_sel = 1'b0;
    @(negedge write_clk);
    check(nm, int'(cpu_rdata), exp);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge write_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    int waited;
    int target;
    reset = 1'b1; cpu_sel = 1'b0; cpu_wr = 1'b0; cpu_reg = 3'd0; cpu_wdata = 8'h00;
    model_reset();
    repeat (2) @(posedge write_clk);
    @(negedge write_clk);
    check("rst_write_enable", int'(write_enable), 0);
    check("rst_write_addr", int'(write_addr), 0);
    check("rst_write_data", int'(write_data), 0);
    check("rst_cpu_rdata", int'(cpu_rdata), 0);
    check("rst_busy", int'(busy), 0);
    @(posedge write_clk); #1;
    reset = 1'b0;
    chk_en = 1'b1;
    idle(1);

    // Basic pointer and data write.
    rd(3, 1, "rd_incr_reset");
    wr(0, 'h34); wr(1, 'h12); wr(2, 'hAB);
    @(negedge write_clk);
    check("pin_we_1234", int'(write_enable), 1);
    check("pin_addr_1234", int'(write_addr), 'h1234);
    check("pin_data_AB", int'(write_data), 'hAB);
    #1;
    rd(0, 'h35, "rd_ptr_lo_35");
    rd(1, 'h12, "rd_ptr_hi_12");
    rd(7, 0, "rd_status_idle");

    // Increment of 0x50 across the top of the address space.
    wr(3, 'h50); wr(0, 'hF0); wr(1, 'hFF);
    wr(2, 'h11);
    @(negedge write_clk);
    check("pin_addr_3FF0", int'(write_addr), 'h3FF0);
    #1;
    wr(2, 'h22);
    @(negedge write_clk);
    check("pin_addr_0040", int'(write_addr), 'h0040);
    #1;
    rd(0, 'h90, "rd_wrap_lo_90");
    rd(1, 'h00, "rd_wrap_hi_00");
    rd(3, 'h50, "rd_incr_50");

    // Increment of zero keeps the pointer fixed.
    wr(3, 0); wr(2, 'h01); wr(2, 'h02);
    rd(0, m_rd(0), "rd_incr0_ptr");

    // Three-byte fill.
    wr(6, 'h7E); wr(3, 1); wr(0, 'h00); wr(1, 'h01); wr(4, 3); wr(5, 0);
    idle(6);
    rd(7, 0, "rd_status_after_fill3");
    rd(0, FILL_EN ? 'h03 : 'h00, "pin_ptr_after_fill3");
    rd(6, FILL_EN ? 'h7E : 'h00, "rd_fill_val");

    // Sixteen-byte fill with CPU writes attempted mid-fill.
    wr(0, 'h00); wr(1, 'h02); wr(4, 16); wr(5, 0);
    rd(7, m_rd(7), "rd_status_midfill");
    wr(2, 'h55); wr(0, 'h00);
    idle(20);
    rd(0, FILL_EN ? 'h10 : 'h00, "pin_ptr_after_fill16");
    rd(1, 'h02, "rd_ptr_hi_after_fill16");

    // Zero-length fill must not start.
    wr(4, 0); wr(5, 0);
    idle(4);
    rd(7, 0, "rd_status_zero_fill");

    // A long fill is cut short by reset.
    wr(3, 1); wr(0, 0); wr(1, 0); wr(4, 100); wr(5, 0);
    target = FILL_EN ? 10 : 0;
    seen = 0; waited = 0;
    while (seen < target && waited < 150) begin
      @(negedge write_clk);
      if (write_enable) seen++;
      waited++;
    end
    check("fill100_strobes_before_reset", seen, target);
    #1;
    reset = 1'b1;
    for (int k = cyc + 1; k <= cyc + 200; k++) begin
      if (exp_addr.exists(k)) exp_addr.delete(k);
      if (exp_busy.exists(k)) exp_busy.delete(k);
    end
    model_reset();
    #1;
    check("async_rst_write_enable", int'(write_enable), 0);
    check("async_rst_busy", int'(busy), 0);
    idle(2);
    reset = 1'b0;
    idle(1);
    rd(0, 0, "rd_ptr_lo_after_reset");
    rd(1, 0, "rd_ptr_hi_after_reset");
    rd(3, 1, "rd_incr_after_reset");
    idle(110);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
